// File: rtl/demux_stream_pkg.sv
// rtl/demux_stream_pkg.sv - shared types and constants for the 1-to-N stream demux
package demux_stream_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int CNT_W     = 16;
    localparam int MAX_N_OUT = 8;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - single-entry output buffer with EMPTY/FULL state
module demux_slot
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] wdata,
    input  logic              drain,
    output logic              valid,
    output logic [DATA_W-1:0] rdata,
    output logic              can_load
);

    slot_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A slot accepts when empty, or when its current word leaves on this edge.
    assign can_load = (state_q == SLOT_EMPTY) | drain;
    assign valid    = (state_q == SLOT_FULL);
    assign rdata    = data_q;

    // Next state: drain and load together keep the slot full with the new word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
        if (load) data_d = wdata;
    end

    // State and data registers; buffered word is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/demux_stream_1xn.sv
// rtl/demux_stream_1xn.sv - registered 1-to-N stream demux, optional drain counters via DEMUX_STREAM_CNT_EN
module demux_stream_1xn
    import demux_stream_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 2,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    err_sel
`ifdef DEMUX_STREAM_CNT_EN
    ,
    output logic [N_OUT*CNT_W-1:0]  cnt_out
`endif
);

    logic [N_OUT-1:0] slot_can_load;
    logic [N_OUT-1:0] slot_load;
    logic [N_OUT-1:0] slot_drain;
    logic [N_OUT-1:0] slot_valid;
    logic             sel_hit;
    logic             err_sel_q, err_sel_d;

    assign slot_drain = slot_valid & out_ready;
    assign out_valid  = slot_valid;
    assign err_sel    = err_sel_q;

    // Decode in_sel: ready follows the addressed slot; unmapped indices are always accepted and dropped.
    always_comb begin
        in_ready  = 1'b1;
        sel_hit   = 1'b0;
        slot_load = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_hit      = 1'b1;
                in_ready     = slot_can_load[k];
                slot_load[k] = in_valid & slot_can_load[k];
            end
        end
        err_sel_d = in_valid & ~sel_hit;
    end

    // One-cycle error pulse for a dropped, unmapped word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_sel_q <= 1'b0;
        else        err_sel_q <= err_sel_d;
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (slot_load[g]),
            .wdata    (in_data),
            .drain    (slot_drain[g]),
            .valid    (slot_valid[g]),
            .rdata    (out_data[g*DATA_W +: DATA_W]),
            .can_load (slot_can_load[g])
        );
    end

`ifdef DEMUX_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_OUT];
    logic [CNT_W-1:0] cnt_d [N_OUT];

    // Count words taken by each consumer; wraps naturally at 2^CNT_W.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (slot_drain[k]) cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
        assign cnt_out[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb/tb_demux_stream_1xn.sv - scoreboard bench for demux_stream_1xn with three channels
module tb_demux_stream_1xn;

    localparam int DW = 8;
    localparam int NO = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [1:0]     in_sel;
    logic [NO-1:0]  out_valid;
    logic [NO-1:0]  out_ready;
    logic [NO*DW-1:0] out_data;
    logic           err_sel;
`ifdef DEMUX_STREAM_CNT_EN
    logic [NO*16-1:0] cnt_out;
`endif

    demux_stream_1xn #(.DATA_W(DW), .N_OUT(NO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel)
`ifdef DEMUX_STREAM_CNT_EN
        ,
        .cnt_out   (cnt_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every drain seen before the edge must match the oldest word expected on that channel.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_en) begin
            for (int k = 0; k < NO; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (idx < 0 && exp_q[j].ch == 2'(k)) idx = j;
                    end
                    if (idx < 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_drain ch=%0d actual=%0h required=none", k, out_data[k*DW +: DW]);
                    end else begin
                        check($sformatf("drain_ch%0d", k), 32'(out_data[k*DW +: DW]), 32'(exp_q[idx].data));
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic send(input logic [1:0] sel, input logic [DW-1:0] d, output int waits);
        logic acc;
        acc      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        while (!acc && waits < 20) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        check("send_accepted", 32'(acc), 32'd1);
        if (acc && sel < 2'(NO)) exp_q.push_back('{ch: sel, data: d});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    int w;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_err_sel", 32'(err_sel), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic route to channel 1.
        out_ready = 3'b111;
        send(2'd1, 8'hA5, w);
        check("basic_valid", 32'(out_valid), 32'h2);
        check("basic_data", 32'(out_data[15:8]), 32'hA5);
        @(posedge clk); #1;
        check("basic_cleared", 32'(out_valid), 32'h0);

        // Backpressure on channel 0.
        out_ready = 3'b110;
        send(2'd0, 8'h11, w);
        check("bp_first_valid", 32'(out_valid[0]), 32'h1);
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h22;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        check("bp_hold_data", 32'(out_data[7:0]), 32'h11);
        check("bp_in_ready_still_low", 32'(in_ready), 32'h0);
        out_ready = 3'b111;
        #1;
        check("bp_in_ready_on_drain", 32'(in_ready), 32'h1);
        exp_q.push_back('{ch: 2'd0, data: 8'h22});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_no_gap_valid", 32'(out_valid[0]), 32'h1);
        check("bp_new_data", 32'(out_data[7:0]), 32'h22);
        @(posedge clk); #1;
        check("bp_emptied", 32'(out_valid), 32'h0);

        // Concurrent channels: channel 1 stalled, channel 0 still accepts.
        out_ready = 3'b000;
        send(2'd1, 8'h33, w);
        send(2'd0, 8'h44, w);
        check("conc_no_wait", 32'(w), 32'd0);
        check("conc_valid", 32'(out_valid), 32'h3);
        check("conc_ch1_data", 32'(out_data[15:8]), 32'h33);
        check("conc_ch0_data", 32'(out_data[7:0]), 32'h44);
        out_ready = 3'b011;
        @(posedge clk); #1;
        check("conc_drained", 32'(out_valid), 32'h0);

        // Out-of-range index with channel 2 stalled.
        out_ready = 3'b000;
        send(2'd2, 8'h55, w);
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h7E;
        #1;
        check("oor_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("oor_err_pulse", 32'(err_sel), 32'h1);
        check("oor_valid_unchanged", 32'(out_valid), 32'h4);
        check("oor_ch2_data", 32'(out_data[23:16]), 32'h55);
        @(posedge clk); #1;
        check("oor_err_one_cycle", 32'(err_sel), 32'h0);
        check("oor_valid_still", 32'(out_valid), 32'h4);

        // Asynchronous reset right after an error pulse, with channel 2 full.
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h7E;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("arst_err_before", 32'(err_sel), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_err_sel", 32'(err_sel), 32'h0);
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_data", 32'(out_data), 32'h0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_no_err_after", 32'(err_sel), 32'h0);
        check("arst_still_empty", 32'(out_valid), 32'h0);

        // Back-to-back traffic across all channels, then drain everything.
        out_ready = 3'b111;
        send(2'd2, 8'hC3, w);
        send(2'd0, 8'h5A, w);
        send(2'd1, 8'h0F, w);
        repeat (3) @(posedge clk);
        #1;
        check("final_empty", 32'(out_valid), 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

`ifdef DEMUX_STREAM_CNT_EN
        rst_n = 1'b0;
        #1;
        check("cnt_reset", 32'(cnt_out[31:0]), 32'h0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        mon_en    = 1'b0;
        out_ready = 3'b001;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 8'h01;
        repeat (65537) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("cnt_ch0_wrapped", 32'(cnt_out[15:0]), 32'd1);
        check("cnt_ch1_zero", 32'(cnt_out[31:16]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
